// File: rtl/ahblite_cmd_master.sv
// AHB-Lite single-transfer initiator driven by a local valid/ready command port.
// Optional data-phase watchdog: define AHB_MASTER_TIMEOUT_EN.
module ahblite_cmd_master #(
  parameter logic [3:0]  HPROT_VAL   = 4'b0011,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic        HWRITE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  // state | meaning
  // IDLE  | cmd_ready high, waiting for a command
  // ADDR  | NONSEQ address phase, held until HREADY
  // DATA  | data phase, waiting for slave completion
  // ERR2  | second cycle of a two-cycle ERROR response
  // RESP  | one-cycle response pulse to the local side
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_ERR2, S_RESP} state_t;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  size_q, size_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        bad_cmd;
  logic        timeout_hit;

  assign bad_cmd = (cmd_size > 3'd2) ||
                   ((cmd_size == 3'd1) && cmd_addr[0]) ||
                   ((cmd_size == 3'd2) && (cmd_addr[1:0] != 2'b00));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    write_d = write_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          size_d  = cmd_size;
          write_d = cmd_write;
          wdata_d = cmd_wdata;
          rdata_d = '0;
          err_d   = bad_cmd;
          state_d = bad_cmd ? S_RESP : S_ADDR;
        end
      end
      S_ADDR: begin
        if (HREADY) state_d = S_DATA;
      end
      S_DATA: begin
        if (HREADY && !HRESP) begin
          if (!write_q) rdata_d = HRDATA;
          state_d = S_RESP;
        end else if (HRESP) begin
          // HREADY with HRESP on the first cycle is a slave protocol slip; still an error.
          if (HREADY) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_ERR2;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_ERR2: begin
        if (HREADY || timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef AHB_MASTER_TIMEOUT_EN
  localparam int unsigned   TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Down-counter reloads on every state change; terminal count marks the last allowed wait cycle.
  always_comb begin
    tmo_d = tmo_q;
    if (state_d != state_q) begin
      tmo_d = TMO_LOAD;
    end else if (((state_q == S_DATA) || (state_q == S_ERR2)) && !HREADY && (tmo_q != '0)) begin
      tmo_d = tmo_q - TMO_W'(1);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) tmo_q <= TMO_LOAD;
    else          tmo_q <= tmo_d;
  end

  assign timeout_hit = (tmo_q == '0);
`else
  logic tmo_unused;
  assign tmo_unused  = (TIMEOUT_CYC == 0);
  assign timeout_hit = 1'b0;
`endif

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_err   = (state_q == S_RESP) && err_q;
  assign rsp_rdata = rdata_q;

  assign HTRANS    = (state_q == S_ADDR) ? TRANS_NONSEQ : TRANS_IDLE;
  assign HADDR     = addr_q;
  assign HSIZE     = size_q;
  assign HWRITE    = write_q;
  assign HWDATA    = wdata_q;
  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahblite_cmd_master.sv
// Directed bench for ahblite_cmd_master; slave behaviour is driven by hand per cycle.
module tb_ahblite_cmd_master;

`ifdef AHB_MASTER_TIMEOUT_EN
  localparam int unsigned TB_TMO = 8;
`else
  localparam int unsigned TB_TMO = 256;
`endif

  logic        HCLK;
  logic        HRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [2:0]  cmd_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [3:0]  HPROT;

  int n_chk  = 0;
  int n_pass = 0;

  ahblite_cmd_master #(.HPROT_VAL(4'b0011), .TIMEOUT_CYC(TB_TMO)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE),
    .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // Presents a command for one edge; returns in the cycle after the accept edge.
  task automatic issue(input logic w, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] wd);
    chk("ready_before_issue", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_size = sz; cmd_wdata = wd;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_size = '0; cmd_wdata = '0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    #3;
    chk("rst_htrans", 32'(HTRANS), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_haddr", HADDR, 32'd0);
    chk("rst_hwdata", HWDATA, 32'd0);
    chk("rst_hsize_hwrite", 32'({HSIZE, HWRITE}), 32'd0);
    chk("tie_hburst", 32'(HBURST), 32'd0);
    chk("tie_hprot", 32'(HPROT), 32'd3);
    chk("tie_hmastlock", 32'(HMASTLOCK), 32'd0);
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    tick();

    // zero-wait write
    issue(1'b1, 32'h4000_0000, 3'd2, 32'h0000_1234);
    chk("wr_nonseq", 32'(HTRANS), 32'd2);
    chk("wr_hwrite", 32'(HWRITE), 32'd1);
    chk("wr_haddr", HADDR, 32'h4000_0000);
    chk("wr_hsize", 32'(HSIZE), 32'd2);
    chk("wr_ready_busy", 32'(cmd_ready), 32'd0);
    tick();
    chk("wr_data_htrans", 32'(HTRANS), 32'd0);
    chk("wr_hwdata", HWDATA, 32'h0000_1234);
    chk("wr_no_rsp_yet", 32'(rsp_valid), 32'd0);
    tick();
    chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("wr_rsp_err", 32'(rsp_err), 32'd0);
    chk("wr_rsp_rdata", rsp_rdata, 32'd0);
    tick();
    chk("wr_rsp_pulse", 32'(rsp_valid), 32'd0);
    chk("wr_ready_again", 32'(cmd_ready), 32'd1);
    chk("hwdata_persist", HWDATA, 32'h0000_1234);

    // read with two data-phase wait states
    issue(1'b0, 32'h4000_0004, 3'd2, 32'h0);
    chk("rd_nonseq", 32'(HTRANS), 32'd2);
    chk("rd_hwrite", 32'(HWRITE), 32'd0);
    tick();
    HREADY = 1'b0; HRDATA = 32'h0BAD_0BAD;
    chk("rd_w1_htrans", 32'(HTRANS), 32'd0);
    chk("rd_w1_ready", 32'(cmd_ready), 32'd0);
    tick();
    chk("rd_w2_ready", 32'(cmd_ready), 32'd0);
    chk("rd_w2_rsp", 32'(rsp_valid), 32'd0);
    tick();
    HREADY = 1'b1; HRDATA = 32'hDEAD_BEEF;
    chk("rd_w3_ready", 32'(cmd_ready), 32'd0);
    tick();
    HRDATA = 32'h5555_5555;
    chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("rd_rsp_err", 32'(rsp_err), 32'd0);
    tick();

    // address phase stalled by HREADY low for two cycles
    HREADY = 1'b0;
    issue(1'b0, 32'h4000_0008, 3'd2, 32'h0);
    chk("stall_c1_htrans", 32'(HTRANS), 32'd2);
    tick();
    chk("stall_c2_htrans", 32'(HTRANS), 32'd2);
    chk("stall_c2_haddr", HADDR, 32'h4000_0008);
    tick();
    HREADY = 1'b1;
    chk("stall_c3_htrans", 32'(HTRANS), 32'd2);
    chk("stall_c3_haddr", HADDR, 32'h4000_0008);
    tick();
    HRDATA = 32'h1234_5678;
    chk("stall_data_htrans", 32'(HTRANS), 32'd0);
    tick();
    chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("stall_rsp_rdata", rsp_rdata, 32'h1234_5678);
    chk("stall_rsp_err", 32'(rsp_err), 32'd0);
    tick();

    // two-cycle ERROR response on a write
    issue(1'b1, 32'h4000_000C, 3'd2, 32'hA5A5_5A5A);
    tick();
    HRESP = 1'b1; HREADY = 1'b0;
    chk("err_c1_htrans", 32'(HTRANS), 32'd0);
    tick();
    HREADY = 1'b1;
    chk("err_c2_htrans", 32'(HTRANS), 32'd0);
    chk("err_c2_rsp", 32'(rsp_valid), 32'd0);
    chk("err_hwdata", HWDATA, 32'hA5A5_5A5A);
    tick();
    HRESP = 1'b0;
    chk("err_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("err_rsp_err", 32'(rsp_err), 32'd1);
    chk("err_rsp_rdata", rsp_rdata, 32'd0);
    tick();

    // misaligned and illegal-size commands never reach the bus
    issue(1'b0, 32'h4000_0002, 3'd2, 32'h0);
    chk("mis_w_htrans", 32'(HTRANS), 32'd0);
    chk("mis_w_rsp", 32'(rsp_valid), 32'd1);
    chk("mis_w_err", 32'(rsp_err), 32'd1);
    tick();
    issue(1'b1, 32'h4000_0001, 3'd1, 32'h0);
    chk("mis_h_htrans", 32'(HTRANS), 32'd0);
    chk("mis_h_err", 32'(rsp_err), 32'd1);
    tick();
    issue(1'b0, 32'h4000_0000, 3'd3, 32'h0);
    chk("size3_htrans", 32'(HTRANS), 32'd0);
    chk("size3_err", 32'(rsp_err), 32'd1);
    tick();

    // aligned halfword is legal
    issue(1'b0, 32'h4000_0002, 3'd1, 32'h0);
    chk("half_nonseq", 32'(HTRANS), 32'd2);
    chk("half_hsize", 32'(HSIZE), 32'd1);
    tick();
    HRDATA = 32'h0000_BEEF;
    tick();
    chk("half_rsp_err", 32'(rsp_err), 32'd0);
    chk("half_rsp_rdata", rsp_rdata, 32'h0000_BEEF);
    tick();

    // HRESP with HREADY in the first data cycle
    issue(1'b0, 32'h4000_0010, 3'd2, 32'h0);
    tick();
    HRESP = 1'b1; HRDATA = 32'hFFFF_FFFF;
    tick();
    HRESP = 1'b0;
    chk("slip_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("slip_rsp_err", 32'(rsp_err), 32'd1);
    chk("slip_rsp_rdata", rsp_rdata, 32'd0);
    tick();

    // reset asserted during the data phase
    issue(1'b1, 32'h4000_0014, 3'd2, 32'hCAFE_0001);
    tick();
    HREADY = 1'b0;
    HRESETn = 1'b0;
    #1;
    chk("arst_htrans", 32'(HTRANS), 32'd0);
    chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("arst_ready", 32'(cmd_ready), 32'd1);
    chk("arst_hwdata", HWDATA, 32'd0);
    #2 HRESETn = 1'b1;
    HREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("arst_no_rsp", 32'(rsp_valid), 32'd0);
    end

    // long data-phase stall
    issue(1'b0, 32'h4000_0018, 3'd2, 32'h0);
    tick();
    HREADY = 1'b0;
`ifdef AHB_MASTER_TIMEOUT_EN
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("tmo_wait_rsp", 32'(rsp_valid), 32'd0);
    end
    tick();
    chk("tmo_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("tmo_rsp_err", 32'(rsp_err), 32'd1);
    chk("tmo_rsp_rdata", rsp_rdata, 32'd0);
    HREADY = 1'b1;
    tick();
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hang_no_rsp", 32'(rsp_valid), 32'd0);
    end
    HREADY = 1'b1; HRDATA = 32'h0000_0042;
    tick();
    chk("hang_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("hang_rsp_err", 32'(rsp_err), 32'd0);
    chk("hang_rsp_rdata", rsp_rdata, 32'h0000_0042);
    tick();
`endif
    chk("end_ready", 32'(cmd_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ahblite_cmd_master.md
Name: ahblite_cmd_master

Overview:
AHB-Lite initiator that turns a simple local command handshake into single, non-burst AHB-Lite transfers. It is the bus-master counterpart to the team's memory-mapped peripheral slaves (display, GPIO, timers), so test sequencers and small controllers can read and write those slaves without a CPU. One outstanding transfer at a time, with no address/data pipelining between commands.

Parameters:
HPROT_VAL, 4'b0011, constant driven on HPROT (non-cacheable, non-bufferable, privileged data).
TIMEOUT_CYC, 256, data-phase wait-state limit; used only when the optional feature is compiled in.

Ports:
HCLK  in  1  bus clock
HRESETn  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  32  byte address
cmd_size  in  3  HSIZE encoding; 0, 1 and 2 are legal
cmd_wdata  in  32  write data, captured at accept
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  read data, valid with rsp_valid; 0 for writes
rsp_err  out  1  error flag, valid with rsp_valid
HADDR  out  32  AHB address
HTRANS  out  2  IDLE (00) or NONSEQ (10) only
HSIZE  out  3  transfer size
HWRITE  out  1  transfer direction
HBURST  out  3  tied to 3'b000 (SINGLE)
HPROT  out  4  HPROT_VAL
HMASTLOCK  out  1  tied to 0
HWDATA  out  32  write data
HRDATA  in  32  read data
HREADY  in  1  bus ready
HRESP  in  1  error response

Behaviour:
- Clock HCLK; reset HRESETn, asynchronous, active-low.
- Reset values: state IDLE; HTRANS=00; HADDR, HWDATA, HSIZE, HWRITE, rsp_rdata = 0; rsp_valid=0; rsp_err=0; cmd_ready=1.
- cmd_ready=1 only in state IDLE. On accept, addr/size/write/wdata are registered.
- FSM states: IDLE, ADDR, DATA, ERR2, RESP.
  - IDLE: on accept, if cmd_size>2, or the address is misaligned (size 1 with addr[0]=1; size 2 with addr[1:0]!=0), go to RESP with rsp_err=1 and no bus transfer. Otherwise go to ADDR.
  - ADDR: drive HTRANS=NONSEQ plus HADDR/HSIZE/HWRITE. Hold them unchanged until HREADY=1 is sampled, then go to DATA.
  - DATA: HTRANS=IDLE. HWDATA holds the captured write data for the whole phase.
    - HREADY=1 & HRESP=0: capture HRDATA (reads only) and go to RESP with err=0.
    - HRESP=1 & HREADY=0: go to ERR2.
  - ERR2: wait for HREADY=1 (HRESP still 1), then go to RESP with err=1 and rdata=0.
  - RESP: rsp_valid=1 for exactly one cycle, then go to IDLE.
- Zero-wait latency: accept at edge N; NONSEQ during cycle N+1; data phase during N+2; rsp_valid during N+3; next accept possible at N+4.
- HWDATA is not cleared between transfers; it changes only on a new accept.
- HRDATA is sampled only on the completing DATA cycle of a read.
- HRESP=1 with HREADY=1 in the first DATA cycle (protocol violation by the slave) is treated as an error completion: go to RESP with err=1.
- Reset asserted mid-transfer: all outputs return to reset values immediately (asynchronous). No response is issued for the aborted command.

Optional Feature:
Macro AHB_MASTER_TIMEOUT_EN.
- Defined: a counter runs while in DATA or ERR2 with HREADY=0. When it reaches TIMEOUT_CYC, the block goes to RESP with rsp_err=1 and rdata=0. HTRANS is already IDLE at that point, and the counter clears on every state change.
- Not defined: no counter; the block waits indefinitely for HREADY.

Test Plan:
- Write 0x4000_0000, size 2, data 0x0000_1234, slave zero-wait -> NONSEQ for one cycle with HWRITE=1; HWDATA=0x1234 in the next cycle; rsp_valid 3 cycles after accept; rsp_err=0.
- Read 0x4000_0004, size 2, slave inserts 2 wait states and returns 0xDEAD_BEEF -> DATA lasts 3 cycles; rsp_rdata=0xDEAD_BEEF; rsp_err=0; cmd_ready=0 throughout.
- Read with HREADY held low for 2 cycles during ADDR (previous transfer stalling) -> HADDR/HTRANS stable for 3 cycles, then normal completion.
- Write with two-cycle ERROR response (HRESP=1/HREADY=0, then HRESP=1/HREADY=1) -> rsp_err=1; HTRANS=IDLE in both error cycles.
- Command addr 0x4000_0002 with size 2 -> no NONSEQ issued; rsp_valid with rsp_err=1 one cycle after accept.
- HRESETn pulsed low during DATA -> HTRANS=00, rsp_valid=0, cmd_ready=1 with no rsp pulse. With AHB_MASTER_TIMEOUT_EN and TIMEOUT_CYC=8, HREADY held low -> rsp_err=1 after 8 wait cycles.
